// File: rtl/rst_release_seq.sv
// rst_release_seq
//   Reset-release sequencer at a clock-domain root. Drives the active-low
//   reset RN_OUT for the downstream flop array. Assertion follows RN
//   immediately and asynchronously. Release is synchronised to CLK through a
//   SYNC_STAGES-deep chain and then held low for a programmable number of
//   edges. A four-phase soft-reset handshake lets a controller re-reset the
//   domain without touching RN.
//
// Ports
//   CLK       in   clock, rising edge
//   RN        in   async active-low reset (pad / POR)
//   SRST_REQ  in   soft-reset request, level, synchronous to CLK
//   RN_OUT    out  active-low downstream reset, straight from a flop
//   SRST_ACK  out  soft-reset acknowledge, registered
//   BUSY      out  registered, 1 whenever the sequencer is not in RUN
//   VDD/VSS   in   power pins, no functional effect
//
// Parameter ranges: SYNC_STAGES 2..4, HOLD_CYCLES 1..255,
// 2**CNT_W > HOLD_CYCLES.

module rst_release_seq #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int CNT_W       = 8
) (
    input  logic CLK,
    input  logic RN,
    input  logic SRST_REQ,
    output logic RN_OUT,
    output logic SRST_ACK,
    output logic BUSY,
    input  logic VDD,
    input  logic VSS
);

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_HOLD  = 2'd1,
        S_RUN   = 2'd2,
        S_SOFT  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [SYNC_STAGES-1:0] sync;
    logic                   sync_out;

    // Power pins are present only for netlist connectivity.
    wire unused_pwr = VDD ^ VSS;

    // Release synchroniser: a 1 walks in from the bottom once RN is high.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) sync <= '0;
        else     sync <= {sync[SYNC_STAGES-2:0], 1'b1};
    end

    assign sync_out = sync[SYNC_STAGES-1];

    // The RESET->HOLD edge already counts as hold edge 0 (counter leaves it
    // at 1), so the power-on release lands on edge SYNC_STAGES+HOLD_CYCLES.
    // With HOLD_CYCLES=1 that same edge goes straight to RUN.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state    <= S_RESET;
            cnt      <= '0;
            RN_OUT   <= 1'b0;
            SRST_ACK <= 1'b0;
            BUSY     <= 1'b1;
        end else begin
            case (state)
                S_RESET, S_HOLD: begin
                    if (state == S_HOLD || sync_out) begin
                        if (cnt == HOLD_LAST) begin
                            // RN_OUT rise and ACK fall are simultaneous here.
                            state    <= S_RUN;
                            cnt      <= '0;
                            RN_OUT   <= 1'b1;
                            SRST_ACK <= 1'b0;
                            BUSY     <= 1'b0;
                        end else begin
                            state <= S_HOLD;
                            cnt   <= cnt + CNT_W'(1);
                        end
                    end
                end
                S_RUN: begin
                    if (SRST_REQ) begin
                        state    <= S_SOFT;
                        cnt      <= '0;
                        RN_OUT   <= 1'b0;
                        SRST_ACK <= 1'b1;
                        BUSY     <= 1'b1;
                    end
                end
                S_SOFT: begin
                    // ACK stays high through the following HOLD; it drops
                    // together with the RN_OUT release.
                    if (!SRST_REQ) begin
                        state <= S_HOLD;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= S_RESET;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rst_release_seq.sv
// tb_rst_release_seq
//   Directed bench for rst_release_seq. A default-parameter instance covers
//   power-on, async assertion, soft reset, deferred request and mid-sequence
//   reset; two extra instances cover the parameter corners. Outputs are
//   checked as {RN_OUT, SRST_ACK, BUSY} 1 ns after each rising edge.

module tb_rst_release_seq;

    logic clk;
    logic rn, req;
    logic rn_out, ack, busy;
    logic rn_c;
    logic c1_out, c1_ack, c1_busy;
    logic c2_out, c2_ack, c2_busy;

    int total;
    int bad;
    int prot_err;
    logic req_q;

    rst_release_seq dut (
        .CLK(clk), .RN(rn), .SRST_REQ(req),
        .RN_OUT(rn_out), .SRST_ACK(ack), .BUSY(busy),
        .VDD(1'b1), .VSS(1'b0)
    );

    rst_release_seq #(.SYNC_STAGES(4), .HOLD_CYCLES(1), .CNT_W(8)) dut_c1 (
        .CLK(clk), .RN(rn_c), .SRST_REQ(1'b0),
        .RN_OUT(c1_out), .SRST_ACK(c1_ack), .BUSY(c1_busy),
        .VDD(1'b1), .VSS(1'b0)
    );

    rst_release_seq #(.SYNC_STAGES(3), .HOLD_CYCLES(255), .CNT_W(8)) dut_c2 (
        .CLK(clk), .RN(rn_c), .SRST_REQ(1'b0),
        .RN_OUT(c2_out), .SRST_ACK(c2_ack), .BUSY(c2_busy),
        .VDD(1'b1), .VSS(1'b0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Requester protocol monitor: REQ must not rise while ACK is high.
    initial begin
        prot_err = 0;
        req_q    = 1'b0;
    end
    always @(posedge clk) begin
        if (req && !req_q && ack) prot_err <= prot_err + 1;
        req_q <= req;
    end

    task automatic test_reset();
        logic [2:0] exp;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            total++;
            if ({rn_out, ack, busy} !== 3'b001) begin
                bad++;
                $display("FAIL reset_hold cyc%0d got=%b want=001", i, {rn_out, ack, busy});
            end
        end
        @(negedge clk); rn = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk); #1;
            exp = (e >= 18) ? 3'b100 : 3'b001;
            total++;
            if ({rn_out, ack, busy} !== exp) begin
                bad++;
                $display("FAIL power_on edge%0d got=%b want=%b", e, {rn_out, ack, busy}, exp);
            end
        end
    endtask

    task automatic test_async();
        logic [2:0] exp;
        @(negedge clk); #1 rn = 1'b0;
        #1;
        total++;
        if ({rn_out, ack, busy} !== 3'b001) begin
            bad++;
            $display("FAIL async_assert got=%b want=001", {rn_out, ack, busy});
        end
        #1 rn = 1'b1;
        for (int e = 1; e <= 19; e++) begin
            @(posedge clk); #1;
            exp = (e >= 18) ? 3'b100 : 3'b001;
            total++;
            if ({rn_out, ack, busy} !== exp) begin
                bad++;
                $display("FAIL async_release edge%0d got=%b want=%b", e, {rn_out, ack, busy}, exp);
            end
        end
    endtask

    task automatic test_soft();
        logic [2:0] exp;
        req = 1'b1;
        for (int e = 1; e <= 24; e++) begin
            @(posedge clk); #1;
            exp = (e >= 22) ? 3'b100 : 3'b011;
            total++;
            if ({rn_out, ack, busy} !== exp) begin
                bad++;
                $display("FAIL soft edge%0d got=%b want=%b", e, {rn_out, ack, busy}, exp);
            end
            if (e == 5) req = 1'b0;
        end
    endtask

    task automatic test_deferred();
        logic [2:0] exp;
        @(posedge clk); #1 rn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); rn = 1'b1;
        for (int e = 1; e <= 37; e++) begin
            @(posedge clk); #1;
            if (e < 18)       exp = 3'b001;
            else if (e == 18) exp = 3'b100;
            else if (e < 36)  exp = 3'b011;
            else              exp = 3'b100;
            total++;
            if ({rn_out, ack, busy} !== exp) begin
                bad++;
                $display("FAIL deferred edge%0d got=%b want=%b", e, {rn_out, ack, busy}, exp);
            end
            if (e == 5)  req = 1'b1;
            if (e == 19) req = 1'b0;
        end
    endtask

    task automatic test_mid_reset();
        logic [2:0] exp;
        req = 1'b1;
        @(posedge clk); #1 req = 1'b0;
        // Next edge enters HOLD with count 0; seven more reach count 7.
        repeat (8) @(posedge clk);
        #1;
        total++;
        if ({rn_out, ack, busy} !== 3'b011) begin
            bad++;
            $display("FAIL mid_hold got=%b want=011", {rn_out, ack, busy});
        end
        #2 rn = 1'b0;
        #1;
        total++;
        if ({rn_out, ack, busy} !== 3'b001) begin
            bad++;
            $display("FAIL mid_assert got=%b want=001", {rn_out, ack, busy});
        end
        @(negedge clk); rn = 1'b1;
        for (int e = 1; e <= 19; e++) begin
            @(posedge clk); #1;
            exp = (e >= 18) ? 3'b100 : 3'b001;
            total++;
            if ({rn_out, ack, busy} !== exp) begin
                bad++;
                $display("FAIL mid_release edge%0d got=%b want=%b", e, {rn_out, ack, busy}, exp);
            end
        end
    endtask

    task automatic test_corners();
        logic [5:0] exp;
        total++;
        if ({c1_out, c1_ack, c1_busy, c2_out, c2_ack, c2_busy} !== 6'b001001) begin
            bad++;
            $display("FAIL corner_reset got=%b want=001001",
                     {c1_out, c1_ack, c1_busy, c2_out, c2_ack, c2_busy});
        end
        @(negedge clk); rn_c = 1'b1;
        for (int e = 1; e <= 262; e++) begin
            @(posedge clk); #1;
            exp = {(e >= 5) ? 3'b100 : 3'b001, (e >= 258) ? 3'b100 : 3'b001};
            total++;
            if ({c1_out, c1_ack, c1_busy, c2_out, c2_ack, c2_busy} !== exp) begin
                bad++;
                $display("FAIL corner edge%0d got=%b want=%b", e,
                         {c1_out, c1_ack, c1_busy, c2_out, c2_ack, c2_busy}, exp);
            end
        end
    endtask

    task automatic test_protocol();
        total++;
        if (prot_err !== 0) begin
            bad++;
            $display("FAIL protocol got=%0d want=0", prot_err);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rn    = 1'b1;
        rn_c  = 1'b1;
        req   = 1'b0;
        #2;
        rn    = 1'b0;
        rn_c  = 1'b0;
        test_reset();
        test_async();
        test_soft();
        test_deferred();
        test_mid_reset();
        test_corners();
        test_protocol();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
